// File: rtl/deserializer_if.sv
// Word-side and serial-side signals of the deserializer.
// The link/consumer side uses the master modport; the deserializer uses the slave modport.
interface deserializer_if #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
);
   logic              data_i;
   logic              data_val_i;
   logic [DATA_W-1:0] deser_data_o;
   logic [MOD_W-1:0]  deser_data_mod_o;
   logic              deser_data_val_o;
   logic              busy_o;

   modport master (
      output data_i, data_val_i,
      input  deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o
   );

   modport slave (
      input  data_i, data_val_i,
      output deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o
   );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel word rebuilder, MSB first, with per-bit valid strobe.
// Define DESER_GAP_FLUSH_EN to flush partial frames (>= 3 bits) after GAP_CYCLES idle cycles.
module deserializer #(
   parameter int DATA_W     = 16,
   parameter int MOD_W      = $clog2(DATA_W),
   parameter int GAP_CYCLES = 4
) (
   input logic             clk_i,
   input logic             srst_i,
   deserializer_if.slave   bus
);
   generate
      if (DATA_W < 4 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_width
         $error("DATA_W must be a power of two, at least 4");
      end
      if (GAP_CYCLES < 1) begin : g_bad_gap
         $error("GAP_CYCLES must be at least 1");
      end
   endgenerate

   logic [DATA_W-1:0] sr;
   logic [MOD_W-1:0]  cnt;
   logic [DATA_W-1:0] data_q;
   logic              val_q;

   // DATA_W is a power of two, so DATA_W-1-cnt is simply ~cnt.
   logic [MOD_W-1:0]  wr_idx;
   assign wr_idx = ~cnt;

   logic last_bit;
   assign last_bit = (cnt == MOD_W'(DATA_W - 1));

`ifdef DESER_GAP_FLUSH_EN
   localparam int IDLE_W = $clog2(GAP_CYCLES + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic [MOD_W-1:0]  mod_q;
   logic              gap_hit;

   assign gap_hit = (cnt != '0) && !bus.data_val_i
                    && (idle_cnt == IDLE_W'(GAP_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sr       <= '0;
         cnt      <= '0;
         idle_cnt <= '0;
         data_q   <= '0;
         mod_q    <= '0;
         val_q    <= 1'b0;
      end else begin
         val_q <= 1'b0;
         if (bus.data_val_i) begin
            idle_cnt <= '0;
            if (last_bit) begin
               data_q <= {sr[DATA_W-1:1], bus.data_i};
               mod_q  <= '0;
               val_q  <= 1'b1;
               cnt    <= '0;
               sr     <= '0;
            end else begin
               sr[wr_idx] <= bus.data_i;
               cnt        <= cnt + MOD_W'(1);
            end
         end else if (gap_hit) begin
            // Frames shorter than 3 bits are treated as line noise and dropped.
            if (cnt >= MOD_W'(3)) begin
               data_q <= sr;
               mod_q  <= cnt;
               val_q  <= 1'b1;
            end
            cnt      <= '0;
            sr       <= '0;
            idle_cnt <= '0;
         end else if (cnt == '0) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IDLE_W'(GAP_CYCLES)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
      end
   end

   assign bus.deser_data_mod_o = mod_q;
`else
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sr     <= '0;
         cnt    <= '0;
         data_q <= '0;
         val_q  <= 1'b0;
      end else begin
         val_q <= 1'b0;
         if (bus.data_val_i) begin
            if (last_bit) begin
               data_q <= {sr[DATA_W-1:1], bus.data_i};
               val_q  <= 1'b1;
               cnt    <= '0;
               sr     <= '0;
            end else begin
               sr[wr_idx] <= bus.data_i;
               cnt        <= cnt + MOD_W'(1);
            end
         end
      end
   end

   assign bus.deser_data_mod_o = '0;
`endif

   assign bus.deser_data_o     = data_q;
   assign bus.deser_data_val_o = val_q;
   assign bus.busy_o           = (cnt != '0);
endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_deserializer;
   localparam int DATA_W     = 16;
   localparam int MOD_W      = $clog2(DATA_W);
   localparam int GAP_CYCLES = 4;

   logic clk_i  = 1'b0;
   logic srst_i = 1'b1;

   deserializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

   deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk_i  (clk_i),
      .srst_i (srst_i),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [MOD_W-1:0]  mod;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void check(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   always @(negedge clk_i) begin
      if (bus.deser_data_val_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got data 0x%0h mod %0d expected no strobe",
                     bus.deser_data_o, bus.deser_data_mod_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_data", bus.deser_data_o, e.data);
            check("strobe_mod", bus.deser_data_mod_o, e.mod);
         end
      end
   end

   task automatic drive(input logic v, input logic d);
      @(negedge clk_i);
      bus.data_val_i = v;
      bus.data_i     = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      for (int i = DATA_W - 1; i >= 0; i--) drive(1'b1, w[i]);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      logic [DATA_W-1:0] w;
      int gaps[16] = '{1, 0, 2, 3, 0, 1, 0, 2, 1, 3, 0, 0, 2, 1, 3, 0};

      bus.data_i     = 1'b0;
      bus.data_val_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("reset_data", bus.deser_data_o, 0);
      check("reset_mod", bus.deser_data_mod_o, 0);
      check("reset_val", bus.deser_data_val_o, 0);
      check("reset_busy", bus.busy_o, 0);
      srst_i = 1'b0;

      // 0xA5C3 with busy profile and exact strobe timing
      w = 16'hA5C3;
      exp_q.push_back('{data: w, mod: '0});
      for (int i = 0; i < DATA_W; i++) begin
         @(negedge clk_i);
         if (i == 0 || i == 1 || i == 15) check("busy_during_word", bus.busy_o, (i != 0));
         bus.data_val_i = 1'b1;
         bus.data_i     = w[DATA_W-1-i];
      end
      @(negedge clk_i);
      bus.data_val_i = 1'b0;
      check("strobe_timing", bus.deser_data_val_o, 1);
      check("busy_after_word", bus.busy_o, 0);
      @(negedge clk_i);
      check("strobe_one_cycle", bus.deser_data_val_o, 0);
      drain("drain_a5c3");

      // back-to-back words
      exp_q.push_back('{data: 16'hFFFF, mod: '0});
      exp_q.push_back('{data: 16'h0001, mod: '0});
      send_word(16'hFFFF);
      send_word(16'h0001);
      idle(1);
      drain("drain_b2b");

      // 0x1234 with short gaps inside the word
      w = 16'h1234;
      exp_q.push_back('{data: w, mod: '0});
      for (int i = 0; i < DATA_W; i++) begin
         drive(1'b1, w[DATA_W-1-i]);
         idle(gaps[i]);
      end
      idle(2);
      drain("drain_gaps");

      // reset mid-word
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b1);
      @(negedge clk_i);
      bus.data_val_i = 1'b0;
      srst_i = 1'b1;
      @(negedge clk_i);
      check("srst_data", bus.deser_data_o, 0);
      check("srst_mod", bus.deser_data_mod_o, 0);
      check("srst_val", bus.deser_data_val_o, 0);
      check("srst_busy", bus.busy_o, 0);
      srst_i = 1'b0;
      exp_q.push_back('{data: 16'h8001, mod: '0});
      send_word(16'h8001);
      idle(2);
      drain("drain_srst");

`ifdef DESER_GAP_FLUSH_EN
      // 5-bit frame 10110 flushed after GAP_CYCLES idle cycles
      drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
      drive(1'b1, 1'b1); drive(1'b1, 1'b0);
      exp_q.push_back('{data: 16'hB000, mod: MOD_W'(5)});
      idle(GAP_CYCLES);
      check("busy_before_flush", bus.busy_o, 1);
      @(negedge clk_i);
      check("flush_timing", bus.deser_data_val_o, 1);
      check("busy_after_flush", bus.busy_o, 0);
      idle(3);
      drain("drain_flush");

      // 2-bit frame discarded silently
      drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      idle(1);
      check("busy_short_frame", bus.busy_o, 1);
      idle(GAP_CYCLES + 3);
      check("busy_after_discard", bus.busy_o, 0);
      check("no_strobe_discard", exp_q.size(), 0);
`else
      // partial word held across a long gap
      w = 16'h5A3C;
      exp_q.push_back('{data: w, mod: '0});
      for (int i = DATA_W - 1; i >= DATA_W - 5; i--) drive(1'b1, w[i]);
      for (int i = 0; i < 50; i++) begin
         drive(1'b0, 1'b0);
         if (i == 0 || i == 10 || i == 49) check("busy_in_gap", bus.busy_o, 1);
      end
      check("no_strobe_in_gap", exp_q.size(), 1);
      for (int i = DATA_W - 6; i >= 0; i--) drive(1'b1, w[i]);
      idle(2);
      drain("drain_hold");
      check("busy_after_hold", bus.busy_o, 0);
`endif

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the serializer: collects a 1-bit serial stream, MSB first, qualified by a per-bit valid strobe, and rebuilds parallel words. It sits at the output of a serial link, between the link and the word-level consumer. With the gap-flush feature it also recovers short frames and reports how many bits are valid.

## Interface
Parameters:
- DATA_W, 16: width of a full word; power of two, at least 4.
- MOD_W, $clog2(DATA_W): width of the bit-count output.
- GAP_CYCLES, 4: consecutive idle cycles that close a partial frame. Used only with DESER_GAP_FLUSH_EN; at least 1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  synchronous, active-high reset.
- data_i  in  1  serial data bit.
- data_val_i  in  1  data_i valid this cycle.
- deser_data_o  out  DATA_W  recovered word, left-aligned.
- deser_data_mod_o  out  MOD_W  valid-bit count; 0 means all DATA_W bits.
- deser_data_val_o  out  1  one-cycle strobe qualifying deser_data_o and deser_data_mod_o.
- busy_o  out  1  partial word held (bit counter non-zero).

## Operation
- State: shift register sr[DATA_W-1:0], bit counter cnt (0..DATA_W-1). With the macro, also an idle counter.
- Each cycle with data_val_i=1:
  - data_i is written to sr[DATA_W-1-cnt], so the first bit lands in the MSB.
  - cnt increments.
- When the bit arriving at cnt=DATA_W-1 is written:
  - The full word loads into deser_data_o, deser_data_mod_o loads 0, deser_data_val_o pulses.
  - cnt wraps to 0 and sr clears.
- Cycles with data_val_i=0 are ignored. Gaps inside a word do not corrupt it and do not add bits.
- No backpressure. The consumer must accept every deser_data_val_o pulse.
- deser_data_o and deser_data_mod_o hold their last value until the next pulse.
- busy_o = (cnt != 0).
- Reset:
  - On srst_i=1: deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0; cnt, sr and idle counter cleared.
  - A word in progress when srst_i is asserted is discarded, and no strobe is issued for it.
  - srst_i has priority over all other events.

## Timing
- Latency: last bit sampled at edge k; deser_data_val_o is high, with data valid, during the cycle after edge k, for exactly one cycle.
- Back-to-back words: the first bit of the next word can be sampled in the same cycle the strobe is high. It is stored at MSB of the new word.
- Minimum spacing between strobes is DATA_W cycles for full words.
- Idle counter (macro only):
  - Counts consecutive data_val_i=0 cycles while cnt != 0.
  - Cleared by any data_val_i=1 and whenever cnt=0.
  - Saturates; it cannot re-fire until cnt becomes non-zero again.
- Flush:
  - Fires at the edge that completes the GAP_CYCLES-th consecutive idle cycle.
  - Outputs update with the same one-cycle latency as a full word.
  - If data_val_i=1 in that cycle, there is no flush: the bit is accepted and the idle counter clears.

## Configuration
- Macro: DESER_GAP_FLUSH_EN.
- Defined: flush on gap.
  - If cnt >= 3, output sr left-aligned with unreceived LSBs 0, deser_data_mod_o=cnt, and pulse deser_data_val_o.
  - If cnt is 1 or 2, silently discard: no strobe, cnt and sr cleared. Minimum frame length is 3 bits.
  - After any flush, busy_o falls.
- Undefined:
  - Idle counter not instantiated.
  - Partial words are held indefinitely across any gap.
  - deser_data_mod_o is constant 0.
  - Only full DATA_W-bit words are emitted.

## Test plan
- Reset, then 16 consecutive valid bits of 0xA5C3 MSB first -> one strobe the cycle after the 16th bit: deser_data_o=0xA5C3, mod=0; busy_o high bits 1-15, low after.
- 0xFFFF then 0x0001 with no idle cycles -> two strobes 16 cycles apart, values 0xFFFF then 0x0001; no dropped or extra bits.
- 0x1234 with random data_val_i gaps of 1-3 cycles (GAP_CYCLES=4, macro defined) -> single strobe, 0x1234, mod=0.
- Macro defined, GAP_CYCLES=4: bits 1,0,1,1,0 then data_val_i=0 -> strobe in the cycle after the 4th idle cycle: deser_data_o=0xB000, mod=5. Then 2 bits followed by a gap -> no strobe, busy_o drops.
- srst_i pulsed after 7 bits of a word, then full 0x8001 -> only 0x8001 strobed; all outputs 0 during reset.
- Macro undefined: 5 bits, 50 idle cycles, 11 more bits -> single strobe with all 16 bits; busy_o high throughout the gap.
